tankb_pf_fetch: RTL
===================

# tankb_pf_fetch

Playfield tile fetch and pixel serializer, directly downstream of the horizontal/vertical timing chain. Consumes the H1..H256 and V1..V128 counts and drives the 32x32 tile VRAM address and the character-ROM address. Serializes each tile row into a 1-bit playfield pixel with a tile colour, aligned to the same H count that addressed it. Output feeds the video mixer.

## Interface
Parameters:
- COLOR_W, 3, width of tile colour (taken from tile code bits [7:8-COLOR_W])

Ports:
- clk  in  1  master clock
- nRESET  in  1  asynchronous, active-low reset
- pix_ce  in  1  one-clk pulse per pixel (M6Hz rate); all state advances only on clk rising with pix_ce=1
- h_cnt  in  9  {H256,H128,H64,H32,H16,H8,H4,H2,H1}
- v_cnt  in  8  {V128..V1}
- vblank  in  1  vertical blanking, high = blank
- vram_addr  out  10  {row[4:0], col[4:0]}
- vram_data  in  8  tile code; valid at the second pix_ce after vram_addr changes
- rom_addr  out  11  {code[7:0], line[2:0]}
- rom_data  in  8  pattern byte, MSB = leftmost pixel; valid at the second pix_ce after rom_addr changes
- pf_pix  out  1  playfield pixel, gated by pf_valid
- pf_color  out  COLOR_W  colour of current tile
- pf_valid  out  1  current pixel is inside the visible area
- flip  in  1  screen flip; present only with TANKB_PF_FLIP_EN

## Operation
- Phase = h_cnt[2:0], sampled on each pix_ce. The fetch for tile column c+1 runs during column c.
- Phase 0: vram_addr <= {v_cnt[7:3], h_cnt[7:3]+1}; column add wraps mod 32.
- Phase 2: code_r <= vram_data; rom_addr <= {vram_data, v_cnt[2:0]}.
- Phase 4: pat_r <= rom_data; col_r <= code_r[7:8-COLOR_W].
- Phase 7: shifter <= pat_r; pf_color <= col_r; pf_valid <= nh[8] & ~vblank, where nh = h_cnt+1 truncated to 9 bits.
- Phases 0–6: shifter <= shifter << 1, zero fill.
- pf_pix = shifter[7] & pf_valid.
- Phases 1, 3, 5, 6: no fetch action; shift only.
- Fetches continue during blanking. Only pf_valid is forced low.
- Counter wrap/load: at h_cnt=0x1FF, nh = 0 makes pf_valid=0 for the following tile. No special case for the 511→128 reload.
- Non-contiguous phases (e.g. counter reload): each pix_ce acts on its sampled phase only. No catch-up fetches.
- Reset (any time, including mid-line): vram_addr=0, rom_addr=0, code_r=0, pat_r=0, col_r=0, shifter=0, pf_color=0, pf_valid=0, pf_pix=0. Normal operation resumes at the first phase-0 pix_ce after release. Output is undefined-free but blank until the next phase 7.

## Timing
- Registered outputs update on the clk edge where pix_ce=1. pf_pix is a gated register output with no extra clk delay.
- Pixel alignment:
  - tile column c, pixel k (h_cnt[2:0]=k) appears on pf_pix during the pix_ce period after the pix_ce where h_cnt[7:3]=c and h_cnt[2:0]=k-1.
  - For k=0, it appears after the phase-7 load of column c-1.
  - Net: one pixel of registered latency relative to h_cnt.
- VRAM and ROM each get 2 pix_ce periods of access time.
- pix_ce=0: all registers hold.

## Configuration
- TANKB_PF_FLIP_EN defined: `flip` port exists. When flip=1:
  - vram_addr = ~{v_cnt[7:3], h_cnt[7:3]+1}
  - rom line = ~v_cnt[2:0]
  - shifter shifts right and pf_pix = shifter[0]
  - flip is sampled at phase 0 and held for the tile.
- Not defined: no `flip` port; behaviour identical to flip=0.

## Test plan
- Reset release, VRAM all 0x00, ROM line pattern 0xFF for code 0, vblank=0:
  - pf_pix=1 and pf_valid=1 for every visible pixel (h_cnt[8]=1) from the second tile onward.
  - pf_pix=0 while h_cnt[8]=0.
- VRAM(row 2, col 5)=0xA3; ROM(0xA3, line 1)=0x81; v_cnt=0x11:
  - vram_addr=0x045 at phase 0 of col 4.
  - rom_addr=0x519 at phase 2.
  - pf_pix pattern 1,0,0,0,0,0,0,1 with pf_color=3'b101 across col 5.
- vblank=1 for a full line:
  - pf_valid=0 and pf_pix=0 throughout.
  - vram_addr still steps once per tile.
- Counter wrap at h_cnt=0x1FF → 0x080:
  - pf_valid=0 for the tile following the wrap.
  - vram_addr column for the wrap fetch is 0x00.
- Assert nRESET low at phase 3 mid-tile:
  - All outputs 0 within the same clk.
  - After release, the first non-zero pf_pix occurs only after a complete phase 0→7 fetch.
- With TANKB_PF_FLIP_EN, flip=1, pattern 0x80, VRAM(0,0):
  - vram_addr=0x3FF is fetched.
  - The set pixel appears last (phase 7) in its tile.

Source files
------------

// File: rtl/tankb_pf_fetch_if.sv
// -----------------------------------------------------------------------------
// tankb_pf_fetch_if
// Bus bundle between the playfield fetcher and its memories / video mixer.
//   vram_addr  : tile VRAM address {row[4:0], col[4:0]}      (fetcher -> VRAM)
//   vram_data  : tile code read back from VRAM                (VRAM -> fetcher)
//   rom_addr   : character ROM address {code[7:0], line[2:0]} (fetcher -> ROM)
//   rom_data   : pattern byte, MSB = leftmost pixel           (ROM -> fetcher)
//   pf_pix     : serialized playfield pixel                   (fetcher -> mixer)
//   pf_color   : colour of the tile currently being shown     (fetcher -> mixer)
//   pf_valid   : current pixel lies in the visible area       (fetcher -> mixer)
// Modports: master = fetcher side, slave = memory / mixer side.
// -----------------------------------------------------------------------------
interface tankb_pf_fetch_if #(
    parameter int COLOR_W = 3
);
    logic [9:0]         vram_addr;
    logic [7:0]         vram_data;
    logic [10:0]        rom_addr;
    logic [7:0]         rom_data;
    logic               pf_pix;
    logic [COLOR_W-1:0] pf_color;
    logic               pf_valid;

    modport master (
        output vram_addr,
        input  vram_data,
        output rom_addr,
        input  rom_data,
        output pf_pix,
        output pf_color,
        output pf_valid
    );

    modport slave (
        input  vram_addr,
        output vram_data,
        input  rom_addr,
        output rom_data,
        input  pf_pix,
        input  pf_color,
        input  pf_valid
    );
endinterface

// File: rtl/tankb_pf_fetch.sv
// -----------------------------------------------------------------------------
// tankb_pf_fetch
// Playfield tile fetch and pixel serializer. During tile column c the block
// fetches the tile code and pattern byte for column c+1, then loads them into
// the pixel shifter at phase 7 so column c+1 starts exactly on its own H count.
//
// Ports:
//   clk     : master clock
//   nRESET  : asynchronous active-low reset
//   pix_ce  : one-clk pixel enable; every register advances only when high
//   h_cnt   : {H256..H1} horizontal count, h_cnt[2:0] is the fetch phase
//   v_cnt   : {V128..V1} vertical count
//   vblank  : vertical blanking, forces pf_valid low for loaded tiles
//   flip    : screen flip, only present when TANKB_PF_FLIP_EN is defined
//   bus     : tankb_pf_fetch_if.master (VRAM/ROM addresses and data,
//             pf_pix / pf_color / pf_valid towards the mixer)
//
// Build option: define TANKB_PF_FLIP_EN to add the flip port. When flip is
// sampled high at phase 0 the tile address and pattern line are inverted and
// that tile is shifted out LSB first.
// -----------------------------------------------------------------------------
module tankb_pf_fetch #(
    parameter int COLOR_W = 3
) (
    input  logic             clk,
    input  logic             nRESET,
    input  logic             pix_ce,
    input  logic [8:0]       h_cnt,
    input  logic [7:0]       v_cnt,
    input  logic             vblank,
`ifdef TANKB_PF_FLIP_EN
    input  logic             flip,
`endif
    tankb_pf_fetch_if.master bus
);

    logic flip_s;
`ifdef TANKB_PF_FLIP_EN
    assign flip_s = flip;
`else
    assign flip_s = 1'b0;
`endif

    logic [9:0]         vram_addr_r, vram_addr_n;
    logic [10:0]        rom_addr_r,  rom_addr_n;
    logic [7:0]         code_r,      code_n;
    logic [7:0]         pat_r,       pat_n;
    logic [COLOR_W-1:0] col_r,       col_n;
    logic [7:0]         shifter_r,   shifter_n;
    logic [COLOR_W-1:0] pf_color_r,  pf_color_n;
    logic               pf_valid_r,  pf_valid_n;
    // armed_r blocks phases 2/4/7 after reset until a fresh phase-0 fetch ran,
    // so stale memory data never reaches the shifter.
    logic               armed_r,     armed_n;
    logic               flip_tile_r, flip_tile_n;
    logic               flip_disp_r, flip_disp_n;

    logic [2:0]         phase_s;
    logic [4:0]         col_next_s;
    logic [9:0]         fetch_addr_s;
    logic [2:0]         line_s;
    logic               nh_msb_s;
    logic [7:0]         shift_s;

    // Tile address, pattern line, next-pixel visibility and shifted pattern.
    always_comb begin
        phase_s      = h_cnt[2:0];
        col_next_s   = h_cnt[7:3] + 5'd1;
        fetch_addr_s = {v_cnt[7:3], col_next_s};
        line_s       = flip_tile_r ? ~v_cnt[2:0] : v_cnt[2:0];
        // Bit 8 of (h_cnt + 1): flips exactly when the low byte carries out.
        nh_msb_s     = h_cnt[8] ^ (&h_cnt[7:0]);
        shift_s      = flip_disp_r ? {1'b0, shifter_r[7:1]} : {shifter_r[6:0], 1'b0};
    end

    // Per-phase fetch and serializer actions; everything holds without pix_ce.
    always_comb begin
        vram_addr_n = vram_addr_r;
        rom_addr_n  = rom_addr_r;
        code_n      = code_r;
        pat_n       = pat_r;
        col_n       = col_r;
        shifter_n   = shifter_r;
        pf_color_n  = pf_color_r;
        pf_valid_n  = pf_valid_r;
        armed_n     = armed_r;
        flip_tile_n = flip_tile_r;
        flip_disp_n = flip_disp_r;
        if (pix_ce) begin
            shifter_n = shift_s;
            case (phase_s)
                3'd0: begin
                    vram_addr_n = flip_s ? ~fetch_addr_s : fetch_addr_s;
                    flip_tile_n = flip_s;
                    armed_n     = 1'b1;
                end
                3'd2: begin
                    if (armed_r) begin
                        code_n     = bus.vram_data;
                        rom_addr_n = {bus.vram_data, line_s};
                    end else begin
                        code_n     = code_r;
                    end
                end
                3'd4: begin
                    if (armed_r) begin
                        pat_n = bus.rom_data;
                        col_n = code_r[7:8-COLOR_W];
                    end else begin
                        pat_n = pat_r;
                    end
                end
                3'd7: begin
                    if (armed_r) begin
                        shifter_n   = pat_r;
                        pf_color_n  = col_r;
                        pf_valid_n  = nh_msb_s & ~vblank;
                        flip_disp_n = flip_tile_r;
                    end else begin
                        shifter_n   = shifter_r;
                    end
                end
                default: begin
                    shifter_n = shift_s;
                end
            endcase
        end else begin
            shifter_n = shifter_r;
        end
    end

    // State register with asynchronous clear of the whole pipeline.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            vram_addr_r <= 10'd0;
            rom_addr_r  <= 11'd0;
            code_r      <= 8'd0;
            pat_r       <= 8'd0;
            col_r       <= '0;
            shifter_r   <= 8'd0;
            pf_color_r  <= '0;
            pf_valid_r  <= 1'b0;
            armed_r     <= 1'b0;
            flip_tile_r <= 1'b0;
            flip_disp_r <= 1'b0;
        end else begin
            vram_addr_r <= vram_addr_n;
            rom_addr_r  <= rom_addr_n;
            code_r      <= code_n;
            pat_r       <= pat_n;
            col_r       <= col_n;
            shifter_r   <= shifter_n;
            pf_color_r  <= pf_color_n;
            pf_valid_r  <= pf_valid_n;
            armed_r     <= armed_n;
            flip_tile_r <= flip_tile_n;
            flip_disp_r <= flip_disp_n;
        end
    end

    assign bus.vram_addr = vram_addr_r;
    assign bus.rom_addr  = rom_addr_r;
    assign bus.pf_color  = pf_color_r;
    assign bus.pf_valid  = pf_valid_r;
    // Gated register output: the visible bit depends on the tile's direction.
    assign bus.pf_pix    = pf_valid_r & (flip_disp_r ? shifter_r[0] : shifter_r[7]);

endmodule
